// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronizer, start/data/parity/stop framing FSM, show-ahead receive FIFO.
// Optional parity checking is enabled by defining UART_RX_PARITY_CHECK_EN.
module uart_rx #(
  parameter int SYSCLK_RATE = 4,
  parameter int BAUD_RATE   = 1,
  parameter int DATA_BITS   = 8,
  parameter int STOP_BITS   = 2,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                                 SysClk,
  input  logic                                 Rst_n,
  input  logic                                 Rx,
  input  logic                                 RxRead,
  output logic [DATA_BITS-1:0]                 RxData,
  output logic                                 RxEmpty,
  output logic                                 RxFull,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]      RxCount,
  output logic                                 FramingErr,
  output logic                                 ParityErr,
  output logic                                 OverrunErr,
  input  logic                                 ErrClear
);

  localparam int DIV = SYSCLK_RATE / BAUD_RATE;
  localparam int CW  = $clog2(DIV);
  localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int NW  = $clog2(FIFO_DEPTH + 1);

  localparam logic [CW-1:0] CNT_MID   = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
  localparam logic [2:0]    DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic [PW-1:0] PTR_LAST  = PW'(FIFO_DEPTH - 1);
  localparam logic [NW-1:0] CNT_FULL  = NW'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  logic                 rx_p0, rx_p1, rx_p2;
  logic                 vld_p0, vld_p1;
  state_t               state;
  logic [CW-1:0]        cnt;
  logic [2:0]           bcnt;
  logic [DATA_BITS-1:0] shift;
  logic                 stop_bad;
`ifdef UART_RX_PARITY_CHECK_EN
  logic                 par;
`endif
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]        wptr, rptr, wptr_nxt, rptr_nxt;
  logic                 fall, tick, frame_done, frame_bad, par_bad, ovr, wr, rd;

  // Synchronizer stages; vld_pN marks when rx_p1 holds a real line sample, so a line
  // that is low out of reset never looks like a falling edge.
  always_ff @(posedge SysClk or negedge Rst_n) begin
    if (!Rst_n) begin
      rx_p0  <= 1'b1;
      rx_p1  <= 1'b1;
      rx_p2  <= 1'b0;
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      rx_p0  <= Rx;
      rx_p1  <= rx_p0;
      rx_p2  <= vld_p1 & rx_p1;
      vld_p0 <= 1'b1;
      vld_p1 <= vld_p0;
    end
  end

  assign fall       = rx_p2 & ~rx_p1;
  assign tick       = (cnt == CNT_LAST);
  assign frame_done = (state == STOP) && tick && (bcnt == STOP_LAST);
  assign frame_bad  = stop_bad | ~rx_p1;
`ifdef UART_RX_PARITY_CHECK_EN
  assign par_bad    = ^{shift, par};
`else
  assign par_bad    = 1'b0;
`endif
  assign rd  = RxRead && (RxCount != '0);
  assign ovr = frame_done && !frame_bad && !par_bad && RxFull && !RxRead;
  assign wr  = frame_done && !frame_bad && !par_bad && (!RxFull || RxRead);

  // Framing FSM
  always_ff @(posedge SysClk or negedge Rst_n) begin
    if (!Rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      bcnt     <= '0;
      shift    <= '0;
      stop_bad <= 1'b0;
`ifdef UART_RX_PARITY_CHECK_EN
      par      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (fall) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          if (cnt == CNT_MID) begin
            cnt   <= '0;
            bcnt  <= '0;
            state <= rx_p1 ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (tick) begin
            cnt   <= '0;
            shift <= (shift >> 1) | (DATA_BITS'(rx_p1) << (DATA_BITS - 1));
            if (bcnt == DATA_LAST) begin
              bcnt  <= '0;
              state <= PARITY;
            end else begin
              bcnt <= bcnt + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PARITY: begin
          if (tick) begin
            cnt      <= '0;
            stop_bad <= 1'b0;
            state    <= STOP;
`ifdef UART_RX_PARITY_CHECK_EN
            par      <= rx_p1;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (tick) begin
            cnt      <= '0;
            stop_bad <= stop_bad | ~rx_p1;
            if (bcnt == STOP_LAST) begin
              bcnt  <= '0;
              state <= IDLE;
            end else begin
              bcnt <= bcnt + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Receive FIFO
  assign wptr_nxt = (wptr == PTR_LAST) ? '0 : wptr + 1'b1;
  assign rptr_nxt = (rptr == PTR_LAST) ? '0 : rptr + 1'b1;

  always_ff @(posedge SysClk) begin
    if (wr) mem[wptr] <= shift;
  end

  always_ff @(posedge SysClk or negedge Rst_n) begin
    if (!Rst_n) begin
      wptr    <= '0;
      rptr    <= '0;
      RxCount <= '0;
      RxData  <= '0;
    end else begin
      if (wr) wptr <= wptr_nxt;
      if (rd) rptr <= rptr_nxt;
      case ({wr, rd})
        2'b10:   RxCount <= RxCount + 1'b1;
        2'b01:   RxCount <= RxCount - 1'b1;
        default: RxCount <= RxCount;
      endcase
      // Head register tracks the entry at rptr; it only changes on a pop or a write into an empty FIFO.
      if (rd) begin
        if (RxCount > NW'(1)) RxData <= mem[rptr_nxt];
        else if (wr)          RxData <= shift;
      end else if (wr && (RxCount == '0)) begin
        RxData <= shift;
      end
    end
  end

  assign RxEmpty = (RxCount == '0);
  assign RxFull  = (RxCount == CNT_FULL);

  // Sticky error flags; a set in the same cycle as ErrClear wins.
  always_ff @(posedge SysClk or negedge Rst_n) begin
    if (!Rst_n) begin
      FramingErr <= 1'b0;
      OverrunErr <= 1'b0;
    end else begin
      FramingErr <= (frame_done && frame_bad) ? 1'b1 : (ErrClear ? 1'b0 : FramingErr);
      OverrunErr <= ovr ? 1'b1 : (ErrClear ? 1'b0 : OverrunErr);
    end
  end

`ifdef UART_RX_PARITY_CHECK_EN
  always_ff @(posedge SysClk or negedge Rst_n) begin
    if (!Rst_n) ParityErr <= 1'b0;
    else        ParityErr <= (frame_done && !frame_bad && par_bad) ? 1'b1 :
                             (ErrClear ? 1'b0 : ParityErr);
  end
`else
  assign ParityErr = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at DIV=4, 8 data bits, 2 stop bits, 8-entry FIFO.
module tb_uart_rx;
  logic       SysClk = 1'b0;
  logic       Rst_n = 1'b0;
  logic       Rx = 1'b1;
  logic       RxRead = 1'b0;
  logic       ErrClear = 1'b0;
  logic [7:0] RxData;
  logic       RxEmpty, RxFull;
  logic [3:0] RxCount;
  logic       FramingErr, ParityErr, OverrunErr;
  int tests = 0;
  int fails = 0;

  uart_rx #(.SYSCLK_RATE(4), .BAUD_RATE(1), .DATA_BITS(8), .STOP_BITS(2), .FIFO_DEPTH(8)) dut (
    .SysClk(SysClk), .Rst_n(Rst_n), .Rx(Rx), .RxRead(RxRead), .RxData(RxData),
    .RxEmpty(RxEmpty), .RxFull(RxFull), .RxCount(RxCount), .FramingErr(FramingErr),
    .ParityErr(ParityErr), .OverrunErr(OverrunErr), .ErrClear(ErrClear)
  );

  always #5 SysClk = ~SysClk;

  initial begin
    #500000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  // Each bit held for 4 clocks; returns 4 clocks after the last stop bit ends.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic s1, input logic s2);
    logic [11:0] bits;
    bits = {s2, s1, p, d, 1'b0};
    @(posedge SysClk); #1;
    for (int i = 0; i < 12; i++) begin
      Rx = bits[i];
      repeat (4) @(posedge SysClk);
      #1;
    end
    Rx = 1'b1;
    repeat (4) @(posedge SysClk);
    #1;
  endtask

  task automatic pop();
    RxRead = 1'b1;
    @(posedge SysClk); #1;
    RxRead = 1'b0;
  endtask

  task automatic clear_errs();
    ErrClear = 1'b1;
    @(posedge SysClk); #1;
    ErrClear = 1'b0;
  endtask

  task automatic test_reset();
    Rst_n = 1'b0;
    repeat (3) @(posedge SysClk); #1;
    tests++; if (RxEmpty !== 1'b1) begin fails++; $display("FAIL reset_empty: got %b expected 1", RxEmpty); end
    tests++; if (RxFull !== 1'b0) begin fails++; $display("FAIL reset_full: got %b expected 0", RxFull); end
    tests++; if (RxCount !== 4'd0) begin fails++; $display("FAIL reset_count: got %0d expected 0", RxCount); end
    tests++; if (RxData !== 8'h00) begin fails++; $display("FAIL reset_data: got %h expected 00", RxData); end
    tests++; if ({FramingErr, ParityErr, OverrunErr} !== 3'b000) begin fails++; $display("FAIL reset_flags: got %b expected 000", {FramingErr, ParityErr, OverrunErr}); end
    Rst_n = 1'b1;
    repeat (5) @(posedge SysClk); #1;
  endtask

  task automatic test_good_frame();
    send_frame(8'hA5, 1'b0, 1'b1, 1'b1);
    tests++; if (RxData !== 8'hA5) begin fails++; $display("FAIL good_data: got %h expected a5", RxData); end
    tests++; if (RxCount !== 4'd1) begin fails++; $display("FAIL good_count: got %0d expected 1", RxCount); end
    tests++; if (RxEmpty !== 1'b0) begin fails++; $display("FAIL good_empty: got %b expected 0", RxEmpty); end
    tests++; if ({FramingErr, ParityErr, OverrunErr} !== 3'b000) begin fails++; $display("FAIL good_flags: got %b expected 000", {FramingErr, ParityErr, OverrunErr}); end
    pop();
    tests++; if (RxEmpty !== 1'b1) begin fails++; $display("FAIL good_pop_empty: got %b expected 1", RxEmpty); end
  endtask

  task automatic test_parity();
    send_frame(8'h01, 1'b0, 1'b1, 1'b1);
`ifdef UART_RX_PARITY_CHECK_EN
    tests++; if (ParityErr !== 1'b1) begin fails++; $display("FAIL parity_flag: got %b expected 1", ParityErr); end
    tests++; if (RxEmpty !== 1'b1) begin fails++; $display("FAIL parity_empty: got %b expected 1", RxEmpty); end
    clear_errs();
    tests++; if (ParityErr !== 1'b0) begin fails++; $display("FAIL parity_clear: got %b expected 0", ParityErr); end
`else
    tests++; if (RxData !== 8'h01) begin fails++; $display("FAIL parity_data: got %h expected 01", RxData); end
    tests++; if (RxCount !== 4'd1) begin fails++; $display("FAIL parity_count: got %0d expected 1", RxCount); end
    tests++; if (ParityErr !== 1'b0) begin fails++; $display("FAIL parity_flag: got %b expected 0", ParityErr); end
    pop();
`endif
  endtask

  task automatic test_framing();
    send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
    tests++; if (FramingErr !== 1'b1) begin fails++; $display("FAIL framing_flag: got %b expected 1", FramingErr); end
    tests++; if (RxCount !== 4'd0) begin fails++; $display("FAIL framing_count: got %0d expected 0", RxCount); end
    tests++; if ({ParityErr, OverrunErr} !== 2'b00) begin fails++; $display("FAIL framing_other: got %b expected 00", {ParityErr, OverrunErr}); end
    clear_errs();
    tests++; if (FramingErr !== 1'b0) begin fails++; $display("FAIL framing_clear: got %b expected 0", FramingErr); end
  endtask

  task automatic test_overrun();
    for (int i = 0; i < 8; i++) send_frame(8'(i), ^(8'(i)), 1'b1, 1'b1);
    tests++; if (RxFull !== 1'b1) begin fails++; $display("FAIL ovr_full: got %b expected 1", RxFull); end
    tests++; if (RxCount !== 4'd8) begin fails++; $display("FAIL ovr_count8: got %0d expected 8", RxCount); end
    tests++; if (OverrunErr !== 1'b0) begin fails++; $display("FAIL ovr_early: got %b expected 0", OverrunErr); end
    send_frame(8'h08, 1'b1, 1'b1, 1'b1);
    tests++; if (OverrunErr !== 1'b1) begin fails++; $display("FAIL ovr_flag: got %b expected 1", OverrunErr); end
    tests++; if (RxCount !== 4'd8) begin fails++; $display("FAIL ovr_count: got %0d expected 8", RxCount); end
    for (int i = 0; i < 8; i++) begin
      tests++; if (RxData !== 8'(i)) begin fails++; $display("FAIL ovr_read%0d: got %h expected %h", i, RxData, 8'(i)); end
      pop();
    end
    tests++; if (RxEmpty !== 1'b1) begin fails++; $display("FAIL ovr_drained: got %b expected 1", RxEmpty); end
    clear_errs();
    tests++; if (OverrunErr !== 1'b0) begin fails++; $display("FAIL ovr_clear: got %b expected 0", OverrunErr); end
  endtask

  task automatic test_read_at_full();
    for (int i = 0; i < 8; i++) send_frame(8'h10 + 8'(i), ^(8'h10 + 8'(i)), 1'b1, 1'b1);
    fork
      send_frame(8'h18, 1'b0, 1'b1, 1'b1);
      begin
        @(posedge SysClk);
        repeat (48) @(posedge SysClk);
        #1 RxRead = 1'b1;
        @(posedge SysClk);
        #1 RxRead = 1'b0;
      end
    join
    tests++; if (OverrunErr !== 1'b0) begin fails++; $display("FAIL rdfull_ovr: got %b expected 0", OverrunErr); end
    tests++; if (RxCount !== 4'd8) begin fails++; $display("FAIL rdfull_count: got %0d expected 8", RxCount); end
    tests++; if (RxData !== 8'h11) begin fails++; $display("FAIL rdfull_head: got %h expected 11", RxData); end
    for (int i = 1; i < 9; i++) begin
      tests++; if (RxData !== 8'h10 + 8'(i)) begin fails++; $display("FAIL rdfull_read%0d: got %h expected %h", i, RxData, 8'h10 + 8'(i)); end
      pop();
    end
    tests++; if (RxEmpty !== 1'b1) begin fails++; $display("FAIL rdfull_drained: got %b expected 1", RxEmpty); end
  endtask

  task automatic test_glitch();
    @(posedge SysClk); #1 Rx = 1'b0;
    @(posedge SysClk); #1 Rx = 1'b1;
    repeat (60) @(posedge SysClk); #1;
    tests++; if (RxEmpty !== 1'b1) begin fails++; $display("FAIL glitch_empty: got %b expected 1", RxEmpty); end
    tests++; if ({FramingErr, ParityErr, OverrunErr} !== 3'b000) begin fails++; $display("FAIL glitch_flags: got %b expected 000", {FramingErr, ParityErr, OverrunErr}); end
    send_frame(8'hC3, 1'b0, 1'b1, 1'b1);
    tests++; if (RxData !== 8'hC3) begin fails++; $display("FAIL glitch_next: got %h expected c3", RxData); end
    pop();
  endtask

  task automatic test_reset_mid_frame();
    send_frame(8'h77, 1'b0, 1'b1, 1'b1);
    tests++; if (RxData !== 8'h77) begin fails++; $display("FAIL rstmid_pre: got %h expected 77", RxData); end
    @(posedge SysClk); #1 Rx = 1'b0;
    repeat (15) @(posedge SysClk);
    #3 Rst_n = 1'b0;
    #1;
    tests++; if (RxData !== 8'h00) begin fails++; $display("FAIL rstmid_data: got %h expected 00", RxData); end
    tests++; if (RxEmpty !== 1'b1) begin fails++; $display("FAIL rstmid_empty: got %b expected 1", RxEmpty); end
    repeat (3) @(posedge SysClk);
    #1 Rst_n = 1'b1;
    repeat (20) @(posedge SysClk);
    #1 Rx = 1'b1;
    repeat (60) @(posedge SysClk); #1;
    tests++; if (RxCount !== 4'd0) begin fails++; $display("FAIL rstmid_count: got %0d expected 0", RxCount); end
    tests++; if ({FramingErr, ParityErr, OverrunErr} !== 3'b000) begin fails++; $display("FAIL rstmid_flags: got %b expected 000", {FramingErr, ParityErr, OverrunErr}); end
    send_frame(8'h5A, 1'b0, 1'b1, 1'b1);
    tests++; if (RxData !== 8'h5A) begin fails++; $display("FAIL rstmid_next: got %h expected 5a", RxData); end
    tests++; if (RxCount !== 4'd1) begin fails++; $display("FAIL rstmid_next_count: got %0d expected 1", RxCount); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_parity();
    test_framing();
    test_overrun();
    test_read_at_full();
    test_glitch();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
